// File: rtl/mac_rx_parser_pkg.sv
// mac_rx_parser_pkg
//   Shared constants and types for the GMII receive parser:
//   - ethertype constants for the ARP/IP demux
//   - preamble / SFD byte values and the broadcast MAC
//   - header byte positions used by the parser FSM
//   - receive FSM state encoding
//   - byte-swap helper used to present the CRC in FCS wire order
package mac_rx_parser_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  localparam logic [3:0]  HDR_DEST_LAST  = 4'd5;
  localparam logic [3:0]  HDR_LAST       = 4'd13;
  localparam logic [3:0]  HDR_BYTES      = 4'd14;
  localparam logic [2:0]  FCS_BYTES      = 3'd4;
  localparam logic [15:0] LEN_MAX        = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_DROP = 3'd4
  } rx_state_e;

  function automatic logic [31:0] swap_bytes32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/CRC32_D8.sv
// CRC32_D8
//   Byte-wide Ethernet CRC32 (poly 04C11DB7, init FFFFFFFF), computed in the
//   reflected (LSB-first) form that matches GMII bit order.
//   o_crc is the final complemented CRC arranged so that o_crc[31:24] is the
//   first FCS byte on the wire and o_crc[7:0] the last.
// Ports
//   i_clk   clock
//   i_rst   asynchronous active-high reset (CRC back to init)
//   i_clr   synchronous clear back to init (start of frame)
//   i_en    fold i_data into the CRC this cycle
//   i_data  data byte
//   o_crc   FCS value in wire-byte order
module CRC32_D8
  import mac_rx_parser_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // One byte of the reflected CRC, one bit per iteration, LSB first.
  always_comb begin
    crc_d = crc_q ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY_REFL) : (crc_d >> 1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_q <= CRC_INIT;
    end else if (i_clr) begin
      crc_q <= CRC_INIT;
    end else if (i_en) begin
      crc_q <= crc_d;
    end
  end

  // Final XOR, then reorder so the first transmitted FCS byte sits in the top byte.
  assign o_crc = swap_bytes32(~crc_q);

endmodule

// File: rtl/mac_rx_parser.sv
// mac_rx_parser
//   GMII receive side of the MAC: hunts preamble/SFD, filters on destination
//   MAC, captures ethertype and source MAC, streams payload bytes with the FCS
//   stripped and reports CRC32 status once per accepted frame.
// Ports
//   i_clk / i_rst            GMII RX clock, asynchronous active-high reset
//   i_local_mac(_valid)      runtime local MAC, loaded whenever valid is high
//   i_gmii_data/_valid       GMII RXD / RX_DV
//   o_recv_data/_valid/_last payload byte stream (no backpressure)
//   o_recv_type/_src_mac     ethertype / source MAC of last accepted header
//   o_recv_len               payload byte count, qualified by o_crc_valid
//   o_crc_valid / o_crc_ok   one-cycle status pulse per accepted frame
module mac_rx_parser
  import mac_rx_parser_pkg::*;
#(
  parameter logic [47:0] P_LOCAL_MAC = 48'h00_00_00_00_00_00,
  parameter bit          P_CRC_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_local_mac,
  input  logic        i_local_mac_valid,
  input  logic [7:0]  i_gmii_data,
  input  logic        i_gmii_valid,
  output logic [7:0]  o_recv_data,
  output logic        o_recv_valid,
  output logic        o_recv_last,
  output logic [15:0] o_recv_type,
  output logic [47:0] o_recv_src_mac,
  output logic [15:0] o_recv_len,
  output logic        o_crc_valid,
  output logic        o_crc_ok
);

  logic [7:0]      gmii_data_q;
  logic            gmii_valid_q;
  logic            prime_q;
  logic            armed_q;
  logic [47:0]     local_mac_q;
  rx_state_e       state_q;
  logic [3:0]      hdr_cnt_q;
  logic [55:0]     hdr_sr_q;
  logic [3:0][7:0] line_q;
  logic [2:0]      fill_q;
  logic [3:0]      rel_cnt_q;
  logic [15:0]     pay_len_q;
  logic [7:0]      pend_data_q;
  logic            pend_vld_q;
  logic            stat_pend_q;
  logic            stat_ok_q;
  logic [15:0]     stat_len_q;

  logic            push_d;
  logic            release_d;
  logic            rel_is_pay_d;
  logic            frame_end_d;
  logic            sfd_d;
  logic            dest_ok_d;
  logic            fcs_match_d;
  logic [47:0]     dest_d;
  logic [31:0]     crc;

  // Header and payload bytes both enter the shift line; a byte only leaves it
  // once four newer bytes are behind it, so the FCS never leaves.
  assign push_d       = gmii_valid_q && ((state_q == ST_HDR) || (state_q == ST_PAY));
  assign release_d    = push_d && (fill_q == FCS_BYTES);
  assign rel_is_pay_d = (rel_cnt_q == HDR_BYTES);
  assign frame_end_d  = !gmii_valid_q && ((state_q == ST_HDR) || (state_q == ST_PAY));
  assign sfd_d        = gmii_valid_q && (gmii_data_q == SFD_BYTE) &&
                        (((state_q == ST_IDLE) && armed_q) || (state_q == ST_PRE));

  // At header byte 5 the previous five dest bytes are in the low end of the header shifter.
  assign dest_d       = {hdr_sr_q[39:0], gmii_data_q};
  assign dest_ok_d    = (dest_d == local_mac_q) || (dest_d == BROADCAST_MAC);

  // Oldest byte of the line is the first FCS byte on the wire.
  assign fcs_match_d  = ({line_q[3], line_q[2], line_q[1], line_q[0]} == crc);

  CRC32_D8 u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (sfd_d),
    .i_en   (release_d),
    .i_data (line_q[3]),
    .o_crc  (crc)
  );

  // Input register stage and local-MAC register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gmii_data_q  <= '0;
      gmii_valid_q <= 1'b0;
      local_mac_q  <= P_LOCAL_MAC;
    end else begin
      gmii_data_q  <= i_gmii_data;
      gmii_valid_q <= i_gmii_valid;
      if (i_local_mac_valid) begin
        local_mac_q <= i_local_mac;
      end
    end
  end

  // Receive FSM, shift line, pending/output stage and status pipeline.
  // armed_q only rises after a genuine idle sample has been seen, so a frame
  // already in flight when reset releases is routed to DROP instead of being
  // parsed from the middle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prime_q        <= 1'b0;
      armed_q        <= 1'b0;
      state_q        <= ST_IDLE;
      hdr_cnt_q      <= '0;
      hdr_sr_q       <= '0;
      line_q         <= '0;
      fill_q         <= '0;
      rel_cnt_q      <= '0;
      pay_len_q      <= '0;
      pend_data_q    <= '0;
      pend_vld_q     <= 1'b0;
      stat_pend_q    <= 1'b0;
      stat_ok_q      <= 1'b0;
      stat_len_q     <= '0;
      o_recv_data    <= '0;
      o_recv_valid   <= 1'b0;
      o_recv_last    <= 1'b0;
      o_recv_type    <= '0;
      o_recv_src_mac <= '0;
      o_recv_len     <= '0;
      o_crc_valid    <= 1'b0;
      o_crc_ok       <= 1'b0;
    end else begin
      prime_q      <= 1'b1;
      if (prime_q && !gmii_valid_q) begin
        armed_q <= 1'b1;
      end
      o_recv_valid <= 1'b0;
      o_recv_last  <= 1'b0;
      o_crc_valid  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (gmii_valid_q) begin
            if (!armed_q) begin
              state_q <= ST_DROP;
            end else if (gmii_data_q == PREAMBLE_BYTE) begin
              state_q <= ST_PRE;
            end else if (gmii_data_q == SFD_BYTE) begin
              state_q <= ST_HDR;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!gmii_valid_q) begin
            state_q <= ST_IDLE;
          end else if (gmii_data_q == SFD_BYTE) begin
            state_q <= ST_HDR;
          end else if (gmii_data_q != PREAMBLE_BYTE) begin
            state_q <= ST_DROP;
          end
        end
        ST_HDR: begin
          if (!gmii_valid_q) begin
            state_q <= ST_IDLE;
          end else begin
            hdr_cnt_q <= hdr_cnt_q + 4'd1;
            hdr_sr_q  <= {hdr_sr_q[47:0], gmii_data_q};
            if ((hdr_cnt_q == HDR_DEST_LAST) && !dest_ok_d) begin
              state_q <= ST_DROP;
            end else if (hdr_cnt_q == HDR_LAST) begin
              state_q        <= ST_PAY;
              o_recv_src_mac <= hdr_sr_q[55:8];
              o_recv_type    <= {hdr_sr_q[7:0], gmii_data_q};
            end
          end
        end
        ST_PAY, ST_DROP: begin
          if (!gmii_valid_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (sfd_d) begin
        hdr_cnt_q  <= '0;
        fill_q     <= '0;
        rel_cnt_q  <= '0;
        pay_len_q  <= '0;
        pend_vld_q <= 1'b0;
      end

      if (push_d) begin
        line_q <= {line_q[2:0], gmii_data_q};
        if (fill_q != FCS_BYTES) begin
          fill_q <= fill_q + 3'd1;
        end
      end

      // The first 14 released bytes are header; everything after is payload.
      // A released payload byte waits in the pending slot until we know
      // whether it is the last one.
      if (release_d) begin
        if (!rel_is_pay_d) begin
          rel_cnt_q <= rel_cnt_q + 4'd1;
        end else begin
          if (pend_vld_q) begin
            o_recv_data  <= pend_data_q;
            o_recv_valid <= 1'b1;
          end
          pend_data_q <= line_q[3];
          pend_vld_q  <= 1'b1;
          if (pay_len_q != LEN_MAX) begin
            pay_len_q <= pay_len_q + 16'd1;
          end
        end
      end

      // An empty pending slot at frame end means no payload was ever released: a runt.
      if (frame_end_d) begin
        if (pend_vld_q) begin
          o_recv_data  <= pend_data_q;
          o_recv_valid <= 1'b1;
          o_recv_last  <= 1'b1;
        end
        pend_vld_q  <= 1'b0;
        fill_q      <= '0;
        stat_pend_q <= 1'b1;
        stat_ok_q   <= pend_vld_q && (P_CRC_CHECK ? fcs_match_d : 1'b1);
        stat_len_q  <= pend_vld_q ? pay_len_q : 16'd0;
      end else begin
        stat_pend_q <= 1'b0;
      end

      // Status goes out one cycle behind the last data byte.
      if (stat_pend_q) begin
        o_crc_valid <= 1'b1;
        o_crc_ok    <= stat_ok_q;
        o_recv_len  <= stat_len_q;
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_parser.sv
// tb_mac_rx_parser
//   Directed bench for mac_rx_parser. Frames are built with a reference FCS,
//   expected payload bytes and status are queued as the frame is driven, and a
//   negedge monitor pops and compares whatever the DUT produces.
module tb_mac_rx_parser;
  import mac_rx_parser_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [47:0] i_local_mac = '0;
  logic        i_local_mac_valid = 1'b0;
  logic [7:0]  i_gmii_data = '0;
  logic        i_gmii_valid = 1'b0;
  logic [7:0]  o_recv_data;
  logic        o_recv_valid;
  logic        o_recv_last;
  logic [15:0] o_recv_type;
  logic [47:0] o_recv_src_mac;
  logic [15:0] o_recv_len;
  logic        o_crc_valid;
  logic        o_crc_ok;

  mac_rx_parser dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_local_mac       (i_local_mac),
    .i_local_mac_valid (i_local_mac_valid),
    .i_gmii_data       (i_gmii_data),
    .i_gmii_valid      (i_gmii_valid),
    .o_recv_data       (o_recv_data),
    .o_recv_valid      (o_recv_valid),
    .o_recv_last       (o_recv_last),
    .o_recv_type       (o_recv_type),
    .o_recv_src_mac    (o_recv_src_mac),
    .o_recv_len        (o_recv_len),
    .o_crc_valid       (o_crc_valid),
    .o_crc_ok          (o_crc_ok)
  );

  always #4 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } exp_t;

  typedef struct {
    logic        ok;
    logic [15:0] len;
    logic [15:0] etype;
    logic [47:0] src;
  } stat_t;

  exp_t       expQ[$];
  stat_t      statQ[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         ignoreOut = 1'b0;
  exp_t       eMon;
  stat_t      sMon;

  localparam logic [47:0] MAC_LOCAL = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC_OTHER = 48'h02_11_22_33_44_56;
  localparam logic [47:0] SRC_A     = 48'hA0_B1_C2_D3_E4_F5;
  localparam logic [47:0] SRC_B     = 48'h10_20_30_40_50_60;
  localparam logic [47:0] SRC_C     = 48'h7E_6D_5C_4B_3A_29;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bit-serial reference CRC over the whole frame queue (no FCS yet).
  function automatic logic [31:0] frameFcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ frm[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                  c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic buildFrame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype,
                            input int plen, input int seed, input int flipIdx);
    logic [31:0] fcs;
    logic [7:0]  b;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    for (int i = 0; i < plen; i++) begin
      b = 8'(seed + 13 * i);
      frm.push_back(b);
    end
    fcs = frameFcs();
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (flipIdx >= 0) begin
      b = frm[14 + flipIdx];
      b[0] = ~b[0];
      frm[14 + flipIdx] = b;
    end
  endtask

  task automatic driveByte(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_gmii_data  = b;
    i_gmii_valid = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      i_gmii_valid = 1'b0;
      i_gmii_data  = 8'h00;
    end
  endtask

  // Drives preamble + SFD + frm; queues expectations when the frame should be accepted.
  task automatic applyStimulus(input bit badPre, input bit accept, input bit crcGood, input int gap);
    int          plen;
    logic [7:0]  b;
    logic [47:0] s;
    plen = frm.size() - 18;
    for (int i = 0; i < 8; i++) begin
      b = (i == 7) ? SFD_BYTE : PREAMBLE_BYTE;
      if (badPre && i == 2) b = 8'h5A;
      driveByte(b);
    end
    for (int i = 0; i < frm.size(); i++) begin
      driveByte(frm[i]);
      if (accept && i >= 14 && i < 14 + plen)
        expQ.push_back('{data: frm[i], last: (i == 13 + plen), cyc: cyc});
    end
    if (accept) begin
      s = '0;
      for (int i = 0; i < 6; i++) s = {s[39:0], frm[6+i]};
      statQ.push_back('{ok: crcGood, len: 16'(plen), etype: {frm[12], frm[13]}, src: s});
    end
    idleCycles(gap);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((expQ.size() != 0 || statQ.size() != 0) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    repeat (4) @(negedge i_clk);
    checkOutput({tag, "_data_left"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_status_left"}, 64'(statQ.size()), 64'd0);
  endtask

  // Output monitor: every data byte and status pulse must match the head of its queue.
  always @(negedge i_clk) begin
    if (!i_rst && !ignoreOut) begin
      if (o_recv_valid) begin
        checkOutput("unexpected_data", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          eMon = expQ.pop_front();
          checkOutput("recv_data", 64'(o_recv_data), 64'(eMon.data));
          checkOutput("recv_last", 64'(o_recv_last), 64'(eMon.last));
          checkOutput("latency", 64'(cyc - eMon.cyc), 64'd7);
        end
      end
      if (o_crc_valid) begin
        checkOutput("unexpected_status", 64'(statQ.size() != 0), 64'd1);
        if (statQ.size() != 0) begin
          sMon = statQ.pop_front();
          checkOutput("crc_ok", 64'(o_crc_ok), 64'(sMon.ok));
          checkOutput("recv_len", 64'(o_recv_len), 64'(sMon.len));
          checkOutput("recv_type", 64'(o_recv_type), 64'(sMon.etype));
          checkOutput("recv_src", 64'(o_recv_src_mac), 64'(sMon.src));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge i_clk);
    checkOutput("rst_valid", 64'(o_recv_valid), 64'd0);
    checkOutput("rst_last", 64'(o_recv_last), 64'd0);
    checkOutput("rst_data", 64'(o_recv_data), 64'd0);
    checkOutput("rst_type", 64'(o_recv_type), 64'd0);
    checkOutput("rst_src", 64'(o_recv_src_mac), 64'd0);
    checkOutput("rst_len", 64'(o_recv_len), 64'd0);
    checkOutput("rst_crc_valid", 64'(o_crc_valid), 64'd0);
    checkOutput("rst_crc_ok", 64'(o_crc_ok), 64'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    idleCycles(4);

    $display("[TB] broadcast ARP, good FCS");
    buildFrame(BROADCAST_MAC, SRC_A, ETHERTYPE_ARP, 28, 5, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    waitDrain("t1");

    $display("[TB] broadcast ARP, payload byte 10 corrupted");
    buildFrame(BROADCAST_MAC, SRC_A, ETHERTYPE_ARP, 28, 5, 10);
    applyStimulus(1'b0, 1'b1, 1'b0, 12);
    waitDrain("t2");

    $display("[TB] runt with header and FCS only");
    buildFrame(BROADCAST_MAC, SRC_B, ETHERTYPE_ARP, 0, 9, -1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12);
    waitDrain("runt");

    $display("[TB] destination filter");
    @(posedge i_clk);
    #1;
    i_local_mac       = MAC_LOCAL;
    i_local_mac_valid = 1'b1;
    @(posedge i_clk);
    #1 i_local_mac_valid = 1'b0;
    buildFrame(MAC_OTHER, SRC_B, ETHERTYPE_IPV4, 30, 21, -1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12);
    waitDrain("t3_drop");
    checkOutput("t3_type_held", 64'(o_recv_type), 64'(ETHERTYPE_ARP));
    buildFrame(MAC_LOCAL, SRC_B, ETHERTYPE_IPV4, 30, 21, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    waitDrain("t3_accept");

    $display("[TB] back-to-back IPv4 frames");
    buildFrame(MAC_LOCAL, SRC_A, ETHERTYPE_IPV4, 46, 33, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    buildFrame(MAC_LOCAL, SRC_C, ETHERTYPE_IPV4, 46, 101, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    waitDrain("t4");

    $display("[TB] bad preamble then good frame");
    buildFrame(BROADCAST_MAC, SRC_C, ETHERTYPE_IPV4, 20, 44, -1);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    waitDrain("t5_drop");
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    waitDrain("t5_good");

    $display("[TB] reset mid-frame");
    buildFrame(BROADCAST_MAC, SRC_C, ETHERTYPE_IPV4, 40, 77, -1);
    ignoreOut = 1'b1;
    for (int i = 0; i < 7; i++) driveByte(PREAMBLE_BYTE);
    driveByte(SFD_BYTE);
    for (int i = 0; i <= 34; i++) driveByte(frm[i]);
    #1 i_rst = 1'b1;
    #1;
    checkOutput("t6_valid", 64'(o_recv_valid), 64'd0);
    checkOutput("t6_data", 64'(o_recv_data), 64'd0);
    checkOutput("t6_type", 64'(o_recv_type), 64'd0);
    checkOutput("t6_src", 64'(o_recv_src_mac), 64'd0);
    checkOutput("t6_crc_valid", 64'(o_crc_valid), 64'd0);
    for (int i = 35; i < 37; i++) driveByte(frm[i]);
    i_rst = 1'b0;
    @(negedge i_clk);
    ignoreOut = 1'b0;
    for (int i = 37; i < frm.size(); i++) driveByte(frm[i]);
    idleCycles(12);
    waitDrain("t6_rest");
    buildFrame(BROADCAST_MAC, SRC_A, ETHERTYPE_ARP, 28, 61, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    waitDrain("t6_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
